evm_ballot_tally: RTL and testbench

Parametrised vote-capture and tally engine for NUM_CAND candidates. It provides per-button debounce, officer-armed one-vote-per-ballot lockout, saturating per-candidate counters, a running total, and registered winner/tie detection. It sits between the raw button inputs and the display/result logic, replacing the fixed six-candidate button, logging and mode path with a single configurable block.

---
 rtl/evm_ballot_tally.sv | 173 +++++++++++++++++
 tb/tb_evm_ballot_tally.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/evm_ballot_tally.sv
// Vote-capture and tally engine: per-button debounce, officer-armed single vote
// per ballot, saturating per-candidate counters, running total, winner/tie flags.
module evm_ballot_tally #(
  parameter int unsigned NUM_CAND = 6,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEBOUNCE = 10,
  parameter int unsigned ACK_CYC  = 10,
  parameter int unsigned IDX_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_arm,
  input  logic [NUM_CAND-1:0] cand_btn,
  input  logic [IDX_W-1:0]    sel_idx,
  output logic                ready,
  output logic                vote_ack,
  output logic                busy,
  output logic [CNT_W-1:0]    result,
  output logic [CNT_W+3:0]    total,
  output logic [IDX_W-1:0]    winner_idx,
  output logic                tie,
  output logic                overflow
);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);
  localparam int unsigned ACK_W = (ACK_CYC > 1) ? $clog2(ACK_CYC) : 1;
  localparam int unsigned TOT_W = CNT_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACK} state_e;

  state_e              state_q, state_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [DEB_W-1:0]    deb_q [NUM_CAND];
  logic [DEB_W-1:0]    deb_d [NUM_CAND];
  logic [CNT_W-1:0]    cnt_q [NUM_CAND];
  logic [CNT_W-1:0]    cnt_d [NUM_CAND];
  logic [TOT_W-1:0]    total_q, total_d;
  logic                overflow_q, overflow_d;
  logic                ready_q, busy_q, vote_ack_q, tie_q;
  logic [IDX_W-1:0]    winner_q;
  logic [CNT_W-1:0]    result_q, result_d;
  logic [NUM_CAND-1:0] press_c;
  logic                vote_c;
  logic [CNT_W-1:0]    max_c;
  logic [IDX_W-1:0]    win_c;
  logic                tie_c;

  // Debounce: run-length counter saturating at DEBOUNCE, press on the reaching edge.
  always_comb begin
    press_c = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      deb_d[i] = deb_q[i];
      if (!cand_btn[i]) begin
        deb_d[i] = '0;
      end else if (deb_q[i] != DEB_W'(DEBOUNCE)) begin
        deb_d[i]   = deb_q[i] + DEB_W'(1);
        press_c[i] = (deb_q[i] == DEB_W'(DEBOUNCE - 1));
      end
    end
  end

  // Ballot FSM; a vote needs exactly one press while armed.
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    vote_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ballot_arm && !mode) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (mode) begin
          state_d = S_IDLE;
        end else if ($countones(press_c) == 1) begin
          vote_c    = 1'b1;
          state_d   = S_ACK;
          ack_cnt_d = '0;
        end
      end
      S_ACK: begin
        if (ack_cnt_q == ACK_W'(ACK_CYC - 1)) state_d = S_IDLE;
        else ack_cnt_d = ack_cnt_q + ACK_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating tallies; a refused increment still completes the ballot.
  always_comb begin
    total_d    = total_q;
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_CAND; i++) cnt_d[i] = cnt_q[i];
    if (vote_c) begin
      if (total_q != '1) total_d = total_q + TOT_W'(1);
      for (int i = 0; i < NUM_CAND; i++) begin
        if (press_c[i]) begin
          if (cnt_q[i] == '1) overflow_d = 1'b1;
          else cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    max_c = cnt_q[0];
    win_c = '0;
    tie_c = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (cnt_q[i] > max_c) begin
        max_c = cnt_q[i];
        win_c = IDX_W'(i);
        tie_c = 1'b0;
      end else if ((cnt_q[i] == max_c) && (max_c != '0)) begin
        tie_c = 1'b1;
      end
    end
  end

  always_comb begin
    result_d = '0;
    if (mode) begin
      for (int i = 0; i < NUM_CAND; i++)
        if (sel_idx == IDX_W'(i)) result_d = cnt_q[i];
    end else if (busy_q) begin
      result_d = '1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ack_cnt_q  <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      vote_ack_q <= 1'b0;
      winner_q   <= '0;
      tie_q      <= 1'b0;
      result_q   <= '0;
      for (int i = 0; i < NUM_CAND; i++) begin
        deb_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ack_cnt_q  <= ack_cnt_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
      ready_q    <= (state_d == S_ARMED);
      busy_q     <= (state_d == S_ACK);
      vote_ack_q <= vote_c;
      winner_q   <= win_c;
      tie_q      <= tie_c;
      result_q   <= result_d;
      for (int i = 0; i < NUM_CAND; i++) begin
        deb_q[i] <= deb_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ready      = ready_q;
  assign vote_ack   = vote_ack_q;
  assign busy       = busy_q;
  assign result     = result_q;
  assign total      = total_q;
  assign winner_idx = winner_q;
  assign tie        = tie_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_evm_ballot_tally.sv
// Bench for evm_ballot_tally: directed and randomized ballots checked every cycle
// against a run-length / ballot-phase reference model.
module tb_evm_ballot_tally;
  localparam int unsigned NC = 6;
  localparam int unsigned CW = 3;
  localparam int unsigned DB = 10;
  localparam int unsigned AC = 10;
  localparam int unsigned IW = 4;
  localparam int unsigned TW = CW + 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TMAX = (1 << TW) - 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, mode, ballot_arm;
  logic [NC-1:0] cand_btn;
  logic [IW-1:0] sel_idx;
  logic          ready, vote_ack, busy, tie, overflow;
  logic [CW-1:0] result;
  logic [TW-1:0] total;
  logic [IW-1:0] winner_idx;

  evm_ballot_tally #(
    .NUM_CAND(NC), .CNT_W(CW), .DEBOUNCE(DB), .ACK_CYC(AC), .IDX_W(IW)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .ballot_arm(ballot_arm),
    .cand_btn(cand_btn), .sel_idx(sel_idx), .ready(ready), .vote_ack(vote_ack),
    .busy(busy), .result(result), .total(total), .winner_idx(winner_idx),
    .tie(tie), .overflow(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_hold [NC];
  int m_cnt  [NC];
  int m_total, m_ack_left, m_result, m_win;
  bit m_ovf, m_armed, m_vote, m_tie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int old_cnt [NC];
    int best, holders, npress, pidx, s;
    bit old_busy;
    old_cnt  = m_cnt;
    old_busy = (m_ack_left > 0);
    if (reset) begin
      foreach (m_cnt[i]) begin m_cnt[i] = 0; m_hold[i] = 0; end
      m_total = 0; m_ack_left = 0; m_result = 0; m_win = 0;
      m_ovf = 0; m_armed = 0; m_vote = 0; m_tie = 0;
      return;
    end
    s = int'(sel_idx);
    if (mode) m_result = (s < NC) ? old_cnt[s] : 0;
    else      m_result = old_busy ? CMAX : 0;
    best = 0;
    foreach (old_cnt[i]) if (old_cnt[i] > best) best = old_cnt[i];
    holders = 0; m_win = -1;
    foreach (old_cnt[i]) if (old_cnt[i] == best) begin
      holders++;
      if (m_win < 0) m_win = i;
    end
    m_tie = (best > 0) && (holders >= 2);
    npress = 0; pidx = 0;
    for (int i = 0; i < NC; i++) begin
      m_hold[i] = cand_btn[i] ? m_hold[i] + 1 : 0;
      if (m_hold[i] == DB) begin npress++; pidx = i; end
    end
    m_vote = 0;
    if (m_ack_left > 0) begin
      m_ack_left--;
    end else if (m_armed) begin
      if (mode) m_armed = 0;
      else if (npress == 1) begin
        m_vote = 1; m_armed = 0; m_ack_left = AC;
        if (m_cnt[pidx] == CMAX) m_ovf = 1; else m_cnt[pidx]++;
        if (m_total < TMAX) m_total++;
      end
    end else if (ballot_arm && !mode) begin
      m_armed = 1;
    end
  endtask

  task automatic step(input bit rst, input bit arm, input bit md,
                      input logic [NC-1:0] btn, input logic [IW-1:0] sel);
    reset = rst; ballot_arm = arm; mode = md; cand_btn = btn; sel_idx = sel;
    @(posedge clock);
    model_edge();
    #1;
    check("ready",      ready,      m_armed);
    check("vote_ack",   vote_ack,   m_vote);
    check("busy",       busy,       m_ack_left > 0);
    check("result",     result,     m_result);
    check("total",      total,      m_total);
    check("winner_idx", winner_idx, m_win);
    check("tie",        tie,        m_tie);
    check("overflow",   overflow,   m_ovf);
  endtask

  task automatic idle(input int n, input bit md, input logic [IW-1:0] sel);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, md, '0, sel);
  endtask

  task automatic hold_btn(input logic [NC-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, b, '0);
  endtask

  task automatic vote(input int k);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    hold_btn(NC'(1) << k, DB);
    idle(AC + 2, 1'b0, '0);
  endtask

  initial begin
    int acks, busys, len, k, gap;
    logic [NC-1:0] b;
    bit md;

    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    idle(3, 1'b0, '0);

    // First vote: single ack pulse, ACK_CYC busy cycles
    acks = 0; busys = 0;
    step(1'b0, 1'b1, 1'b0, '0, '0);
    for (int i = 0; i < DB; i++) begin
      step(1'b0, 1'b0, 1'b0, NC'(4), '0);
      acks += int'(vote_ack); busys += int'(busy);
    end
    for (int i = 0; i < AC + 3; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, '0);
      acks += int'(vote_ack); busys += int'(busy);
    end
    check("t1_ack_pulses", acks, 1);
    check("t1_busy_cycles", busys, AC);
    check("t1_total", total, 1);
    check("t1_winner", winner_idx, 2);
    step(1'b0, 1'b0, 1'b1, '0, IW'(2));
    check("t1_count2", result, 1);

    // Unarmed hold, then arm with button still held
    hold_btn(NC'(1), 20);
    check("t2_not_ready", ready, 0);
    step(1'b0, 1'b1, 1'b0, NC'(1), '0);
    hold_btn(NC'(1), 5);
    check("t2_held_ready", ready, 1);
    check("t2_held_total", total, 1);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    hold_btn(NC'(1), DB);
    idle(AC + 2, 1'b0, '0);
    check("t2_total", total, 2);

    // Simultaneous presses rejected, then single press accepted
    step(1'b0, 1'b1, 1'b0, '0, '0);
    hold_btn(NC'(6'b010010), DB + 1);
    check("t3_still_ready", ready, 1);
    check("t3_no_count", total, 2);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    hold_btn(NC'(6'b010000), DB);
    idle(AC + 2, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0, IW'(4));
    check("t3_count4", result, 1);

    // Tie resolution and break
    vote(3); vote(3); vote(5); vote(5);
    check("t4_tie", tie, 1);
    check("t4_winner", winner_idx, 3);
    vote(5);
    check("t4_untie", tie, 0);
    check("t4_winner5", winner_idx, 5);

    // Abort by mode, and mode during ACK leaves hold intact
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    check("t5_abort", ready, 0);
    idle(2, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    hold_btn(NC'(2), DB);
    idle(AC + 2, 1'b1, IW'(1));
    idle(2, 1'b0, '0);

    // Randomized ballots, biased to saturate candidate 0 and total
    for (int n = 0; n < 240; n++) begin
      k   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NC - 1)) : 0;
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(10, 14));
      b   = NC'(1) << k;
      if ($urandom_range(0, 9) == 0) b = b | (NC'(1) << $urandom_range(0, NC - 1));
      step(1'b0, 1'b1, 1'b0, '0, '0);
      if ($urandom_range(0, 15) == 0) step(1'b0, 1'b0, 1'b1, '0, IW'($urandom_range(0, 15)));
      for (int i = 0; i < len; i++) step(1'b0, 1'b0, 1'b0, b, '0);
      gap = int'($urandom_range(0, 14));
      for (int i = 0; i < gap; i++) begin
        md = ($urandom_range(0, 3) == 0);
        step(1'b0, 1'b0, md, NC'($urandom_range(0, 3) == 0 ? $urandom : 0), IW'($urandom_range(0, 15)));
      end
    end
    idle(AC + 2, 1'b0, '0);
    check("rnd_overflow", overflow, 1);

    // Result view across all select values including out-of-range
    for (int s = 0; s < 16; s++) step(1'b0, 1'b0, 1'b1, '0, IW'(s));
    step(1'b0, 1'b0, 1'b1, '0, IW'(0));
    check("sat_count0", result, CMAX);

    // Reset in the middle of an ACK hold
    idle(2, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    hold_btn(NC'(8), DB);
    idle(3, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0);
    check("rst_busy", busy, 0);
    check("rst_total", total, 0);
    for (int s = 0; s < NC; s++) step(1'b0, 1'b0, 1'b1, '0, IW'(s));
    step(1'b0, 1'b0, 1'b1, '0, IW'(NC - 1));
    check("rst_count", result, 0);
    idle(3, 1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
